ll_st_asym_rx_pack: RTL and testbench

// - Receive-side logic-link FIFO and asymmetric packer for AXI-ST slaves, generalising the fixed full/half/quarter slave receive path.
// - Words from the PHY deframer are buffered, then packed 1, 2 or 4 per user beat; the ratio is runtime-selectable.
// - Returns one credit per word to the far side and holds credits back while the link is offline.
// - Sits between the *_concat deframer and the *_name user unpacker.

---
 rtl/ll_asym_pkg.sv | 31 +++
 rtl/ll_asym_rx_fifo.sv | 52 +++++
 rtl/ll_st_asym_rx_pack.sv | 162 ++++++++++++++++
 tb/tb_ll_st_asym_rx_pack.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ll_asym_pkg.sv
// Shared types and constants for the asymmetric logic-link receive packer.
// Ratio encodings, packer states and debug-word bit positions live here.
package ll_asym_pkg;

  typedef enum logic [1:0] {
    RATIO_X1 = 2'd0,
    RATIO_X2 = 2'd1,
    RATIO_X4 = 2'd2
  } ratio_e;

  typedef enum logic {
    PACK_FILL = 1'b0,
    PACK_HOLD = 1'b1
  } pack_state_e;

  localparam int DBG_COUNT_LSB = 0;
  localparam int DBG_CRED_LSB  = 8;
  localparam int DBG_OVERFLOW  = 16;
  localparam int DBG_RATIO_LSB = 17;
  localparam int DBG_HOLD      = 19;
  localparam int DBG_RX_ONLINE = 20;

  function automatic int unsigned ratio_words(input ratio_e r);
    case (r)
      RATIO_X2: return 2;
      RATIO_X4: return 4;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/ll_asym_rx_fifo.sv
// Receive word FIFO: power-of-two depth, registered pointers, synchronous flush.
// The head word is read combinationally so a pop can land in the packer the same cycle.
module ll_asym_rx_fifo #(
  parameter int WORD_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WORD_W-1:0]          push_data,
  input  logic                       pop,
  output logic [WORD_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              do_push;
  logic              do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ll_st_asym_rx_pack.sv
// Receive-side logic-link FIFO plus 1/2/4-to-1 word packer feeding an AXI-ST user beat.
// Returns one credit per consumed word and resynchronises everything when RX drops.
module ll_st_asym_rx_pack
  import ll_asym_pkg::*;
#(
  parameter int WORD_W    = 128,
  parameter int MAX_RATIO = 4,
  parameter int DEPTH     = 16
) (
  input  logic                        clk_wr,
  input  logic                        rst_wr_n,
  input  logic                        rx_online,
  input  logic                        tx_online,
  input  logic [1:0]                  ratio_sel,
  input  logic [WORD_W-1:0]           rx_i_data,
  input  logic                        rx_i_pushbit,
  output logic                        tx_i_credit,
  output logic [MAX_RATIO*WORD_W-1:0] user_tdata,
  output logic [MAX_RATIO-1:0]        user_enable,
  output logic                        user_tvalid,
  input  logic                        user_tready,
  output logic [31:0]                 rx_debug_status
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int SLOT_W = (MAX_RATIO > 1) ? $clog2(MAX_RATIO) : 1;

  pack_state_e                 state_reg, state_next;
  logic [SLOT_W-1:0]           slot_reg, slot_next;
  logic [MAX_RATIO*WORD_W-1:0] data_reg, data_next;
  ratio_e                      act_ratio_reg, act_ratio_next;
  logic [CNT_W-1:0]            cred_pend_reg, cred_pend_next;
  logic                        overflow_reg;
  logic                        rx_online_reg;

  logic              flush, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [WORD_W-1:0] head_data;
  ratio_e            sel_ratio, eff_ratio;
  logic [SLOT_W-1:0] last_slot;
  int unsigned       act_words;

  assign flush = rx_online_reg && !rx_online;
  assign push  = rx_online && rx_i_pushbit;
  assign pop   = !fifo_empty && !flush &&
                 ((state_reg == PACK_FILL) || user_tready);

  ll_asym_rx_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk_wr),
    .rst_n     (rst_wr_n),
    .flush     (flush),
    .push      (push),
    .push_data (rx_i_data),
    .pop       (pop),
    .head      (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Ratios wider than the instance supports fall back to x1, as does the reserved code.
  always_comb begin
    sel_ratio = RATIO_X1;
    case (ratio_sel)
      2'd1:    if (MAX_RATIO >= 2) sel_ratio = RATIO_X2;
      2'd2:    if (MAX_RATIO >= 4) sel_ratio = RATIO_X4;
      default: sel_ratio = RATIO_X1;
    endcase
  end

  // The ratio is only sampled at a beat boundary so a beat never changes shape mid-fill.
  assign eff_ratio = ((state_reg == PACK_FILL) && (slot_reg == '0)) ? sel_ratio : act_ratio_reg;
  assign last_slot = SLOT_W'(ratio_words(eff_ratio) - 1);
  assign act_words = ratio_words(act_ratio_reg);

  always_comb begin
    state_next     = state_reg;
    slot_next      = slot_reg;
    data_next      = data_reg;
    act_ratio_next = eff_ratio;
    case (state_reg)
      PACK_FILL: begin
        if (pop) begin
          data_next[int'(slot_reg)*WORD_W +: WORD_W] = head_data;
          if (slot_reg == last_slot) begin
            state_next = PACK_HOLD;
            slot_next  = '0;
          end else begin
            slot_next = slot_reg + SLOT_W'(1);
          end
        end
      end
      PACK_HOLD: begin
        if (user_tready) begin
          data_next  = '0;
          state_next = PACK_FILL;
          slot_next  = '0;
          if (pop) begin
            data_next[0 +: WORD_W] = head_data;
            if (last_slot == '0) state_next = PACK_HOLD;
            else                 slot_next  = SLOT_W'(1);
          end
        end
      end
      default: state_next = PACK_FILL;
    endcase
    if (flush) begin
      state_next = PACK_FILL;
      slot_next  = '0;
      data_next  = '0;
    end
  end

  // Credits are suppressed in the flush cycle because the pool is reloaded to DEPTH.
  assign tx_i_credit = tx_online && (cred_pend_reg != '0) && !flush;

  always_comb begin
    cred_pend_next = cred_pend_reg;
    if (flush)                    cred_pend_next = CNT_W'(DEPTH);
    else if (pop && !tx_i_credit) cred_pend_next = cred_pend_reg + CNT_W'(1);
    else if (!pop && tx_i_credit) cred_pend_next = cred_pend_reg - CNT_W'(1);
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_reg     <= PACK_FILL;
      slot_reg      <= '0;
      data_reg      <= '0;
      act_ratio_reg <= RATIO_X1;
      cred_pend_reg <= CNT_W'(DEPTH);
      overflow_reg  <= 1'b0;
      rx_online_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      data_reg      <= data_next;
      act_ratio_reg <= act_ratio_next;
      cred_pend_reg <= cred_pend_next;
      rx_online_reg <= rx_online;
      if (push && fifo_full) overflow_reg <= 1'b1;
    end
  end

  assign user_tvalid = (state_reg == PACK_HOLD);
  assign user_tdata  = data_reg;
  assign user_enable = user_tvalid ? MAX_RATIO'((32'd1 << act_words) - 32'd1) : '0;

  always_comb begin
    rx_debug_status                              = '0;
    rx_debug_status[DBG_COUNT_LSB +: 8]          = 8'(fifo_count);
    rx_debug_status[DBG_CRED_LSB +: 8]           = 8'(cred_pend_reg);
    rx_debug_status[DBG_OVERFLOW]                = overflow_reg;
    rx_debug_status[DBG_RATIO_LSB +: 2]          = act_ratio_reg;
    rx_debug_status[DBG_HOLD]                    = user_tvalid;
    rx_debug_status[DBG_RX_ONLINE]               = rx_online;
  end

endmodule

// File: tb/tb_ll_st_asym_rx_pack.sv
// Scoreboard bench for ll_st_asym_rx_pack: stimulus queues expected beats, a monitor pops and compares.
module tb_ll_st_asym_rx_pack;

  localparam int WORD_W    = 128;
  localparam int MAX_RATIO = 4;
  localparam int DEPTH     = 16;
  localparam int BEAT_W    = WORD_W * MAX_RATIO;

  logic                 clk_wr = 1'b0;
  logic                 rst_wr_n = 1'b0;
  logic                 rx_online = 1'b0;
  logic                 tx_online = 1'b0;
  logic [1:0]           ratio_sel = 2'd0;
  logic [WORD_W-1:0]    rx_i_data = '0;
  logic                 rx_i_pushbit = 1'b0;
  logic                 tx_i_credit;
  logic [BEAT_W-1:0]    user_tdata;
  logic [MAX_RATIO-1:0] user_enable;
  logic                 user_tvalid;
  logic                 user_tready = 1'b0;
  logic [31:0]          rx_debug_status;

  typedef struct {
    logic [BEAT_W-1:0]    data;
    logic [MAX_RATIO-1:0] en;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    credit_cnt = 0;

  ll_st_asym_rx_pack #(
    .WORD_W    (WORD_W),
    .MAX_RATIO (MAX_RATIO),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_wr          (clk_wr),
    .rst_wr_n        (rst_wr_n),
    .rx_online       (rx_online),
    .tx_online       (tx_online),
    .ratio_sel       (ratio_sel),
    .rx_i_data       (rx_i_data),
    .rx_i_pushbit    (rx_i_pushbit),
    .tx_i_credit     (tx_i_credit),
    .user_tdata      (user_tdata),
    .user_enable     (user_enable),
    .user_tvalid     (user_tvalid),
    .user_tready     (user_tready),
    .rx_debug_status (rx_debug_status)
  );

  always #5 clk_wr = ~clk_wr;

  function automatic logic [WORD_W-1:0] mkw(input int n);
    return {32'hC0DE_0000 | 32'(n), 32'(n * 7 + 1), ~32'(n), 32'hA5A5_0000 + 32'(n)};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [BEAT_W-1:0] d, input logic [MAX_RATIO-1:0] e);
    beat_t b;
    b.data = d;
    b.en   = e;
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic push_word(input logic [WORD_W-1:0] w);
    rx_i_pushbit = 1'b1;
    rx_i_data    = w;
    step();
    rx_i_pushbit = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || user_tvalid) && n < 200) begin
      step();
      n++;
    end
    check32("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check32("drain_tvalid_low", 32'(user_tvalid), 32'd0);
  endtask

  // Monitor: counts credit pulses and scores every accepted beat against the queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk_wr);
      if (tx_i_credit) credit_cnt++;
      if (user_tvalid && user_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got data %0h en %0h expected no beat", user_tdata, user_enable);
        end else begin
          e = exp_q.pop_front();
          check_beat("beat_data", user_tdata, e.data);
          check32("beat_enable", 32'(user_enable), 32'(e.en));
          $display("beat: en=%0h data=%0h", user_enable, user_tdata);
        end
      end
    end
  end

  initial begin
    int c0;
    int c1;
    int pushed;
    logic [WORD_W-1:0] w [8];
    logic [WORD_W-1:0] wa, wb, wc, d0, d1;

    // Reset state
    repeat (3) @(posedge clk_wr);
    #1;
    check32("rst_tvalid", 32'(user_tvalid), 32'd0);
    check32("rst_enable", 32'(user_enable), 32'd0);
    check32("rst_credit", 32'(tx_i_credit), 32'd0);
    check_beat("rst_tdata", user_tdata, '0);
    check32("rst_debug", rx_debug_status, 32'h0000_1000);

    rst_wr_n  = 1'b1;
    rx_online = 1'b1;
    step();
    check32("online_debug", rx_debug_status, 32'h0010_1000);

    // Initial credit drain
    c0 = credit_cnt;
    tx_online = 1'b1;
    repeat (20) step();
    check32("init_credit_pulses", 32'(credit_cnt - c0), 32'd16);
    check32("init_cred_pend", 32'(rx_debug_status[15:8]), 32'd0);
    check32("init_tvalid", 32'(user_tvalid), 32'd0);
    pushed = 0;

    // x1: A,B,C back to back, beats at N+2..N+4
    wa = mkw(1); wb = mkw(2); wc = mkw(3);
    ratio_sel   = 2'd0;
    user_tready = 1'b1;
    rx_i_pushbit = 1'b1;
    rx_i_data = wa; expect_beat({384'h0, wa}, 4'b0001);
    step();
    check32("x1_n1_tvalid", 32'(user_tvalid), 32'd0);
    rx_i_data = wb; expect_beat({384'h0, wb}, 4'b0001);
    step();
    check32("x1_n2_tvalid", 32'(user_tvalid), 32'd1);
    check_beat("x1_n2_data", user_tdata, {384'h0, wa});
    check32("x1_n2_enable", 32'(user_enable), 32'd1);
    rx_i_data = wc; expect_beat({384'h0, wc}, 4'b0001);
    step();
    rx_i_pushbit = 1'b0;
    check_beat("x1_n3_data", user_tdata, {384'h0, wb});
    step();
    check_beat("x1_n4_data", user_tdata, {384'h0, wc});
    check32("x1_n4_tvalid", 32'(user_tvalid), 32'd1);
    pushed += 3;
    wait_idle();
    repeat (2) step();
    check32("x1_invariant", 32'(rx_debug_status[7:0]) + 32'(rx_debug_status[15:8])
            + 32'(credit_cnt - c0 - pushed), 32'd16);

    // x4: eight words, first beat held with tready low
    user_tready = 1'b0;
    ratio_sel   = 2'd2;
    step();
    for (int i = 0; i < 8; i++) w[i] = mkw(16 + i);
    expect_beat({w[3], w[2], w[1], w[0]}, 4'hF);
    expect_beat({w[7], w[6], w[5], w[4]}, 4'hF);
    for (int i = 0; i < 8; i++) push_word(w[i]);
    pushed += 8;
    check32("x4_hold_tvalid", 32'(user_tvalid), 32'd1);
    check_beat("x4_hold_data", user_tdata, {w[3], w[2], w[1], w[0]});
    check32("x4_hold_enable", 32'(user_enable), 32'hF);
    check32("x4_fifo_count", 32'(rx_debug_status[7:0]), 32'd4);
    check32("x4_dbg_hold", 32'(rx_debug_status[19]), 32'd1);
    check32("x4_dbg_ratio", 32'(rx_debug_status[18:17]), 32'd2);
    repeat (2) step();
    check_beat("x4_hold_stable", user_tdata, {w[3], w[2], w[1], w[0]});
    user_tready = 1'b1;
    wait_idle();
    repeat (2) step();
    check32("x4_invariant", 32'(rx_debug_status[7:0]) + 32'(rx_debug_status[15:8])
            + 32'(credit_cnt - c0 - pushed), 32'd16);

    // Ratio change mid-beat: x2 beat completes, next beat uses x1
    d0 = mkw(40); d1 = mkw(41);
    ratio_sel = 2'd1;
    repeat (2) step();
    expect_beat({256'h0, d1, d0}, 4'b0011);
    push_word(d0);
    step();
    ratio_sel = 2'd0;
    push_word(d1);
    step();
    check32("rc_x2_tvalid", 32'(user_tvalid), 32'd1);
    check32("rc_x2_enable", 32'(user_enable), 32'b0011);
    check32("rc_x2_dbg_ratio", 32'(rx_debug_status[18:17]), 32'd1);
    wait_idle();
    expect_beat({384'h0, mkw(42)}, 4'b0001);
    push_word(mkw(42));
    wait_idle();
    check32("rc_x1_dbg_ratio", 32'(rx_debug_status[18:17]), 32'd0);
    // Reserved ratio code packs as x1
    ratio_sel = 2'd3;
    step();
    expect_beat({384'h0, mkw(43)}, 4'b0001);
    push_word(mkw(43));
    wait_idle();
    check32("reserved_dbg_ratio", 32'(rx_debug_status[18:17]), 32'd0);
    pushed += 4;
    repeat (2) step();
    check32("rc_invariant", 32'(rx_debug_status[7:0]) + 32'(rx_debug_status[15:8])
            + 32'(credit_cnt - c0 - pushed), 32'd16);

    // Overflow: packer holds one word, 17 more pushes, last one dropped
    tx_online   = 1'b0;
    user_tready = 1'b0;
    ratio_sel   = 2'd0;
    step();
    c1 = credit_cnt;
    push_word(mkw(60));
    repeat (2) step();
    check32("ovf_pre_overflow", 32'(rx_debug_status[16]), 32'd0);
    for (int i = 1; i <= 17; i++) push_word(mkw(60 + i));
    step();
    check32("ovf_count", 32'(rx_debug_status[7:0]), 32'd16);
    check32("ovf_sticky", 32'(rx_debug_status[16]), 32'd1);
    check32("ovf_cred_pend", 32'(rx_debug_status[15:8]), 32'd1);
    check32("ovf_tvalid", 32'(user_tvalid), 32'd1);
    check_beat("ovf_hold_data", user_tdata, {384'h0, mkw(60)});

    // RX drop during HOLD flushes everything next cycle
    rx_online = 1'b0;
    step();
    check32("flush_tvalid", 32'(user_tvalid), 32'd0);
    check32("flush_count", 32'(rx_debug_status[7:0]), 32'd0);
    check32("flush_cred_pend", 32'(rx_debug_status[15:8]), 32'd16);
    check32("flush_overflow_kept", 32'(rx_debug_status[16]), 32'd1);
    check32("flush_dbg_rx_online", 32'(rx_debug_status[20]), 32'd0);
    push_word(mkw(99));
    step();
    check32("offline_push_ignored", 32'(rx_debug_status[7:0]), 32'd0);
    rx_online = 1'b1;
    repeat (3) step();
    check32("tx_off_no_credits", 32'(credit_cnt - c1), 32'd0);
    tx_online = 1'b1;
    repeat (20) step();
    check32("tx_on_credit_pulses", 32'(credit_cnt - c1), 32'd16);
    check32("tx_on_cred_pend", 32'(rx_debug_status[15:8]), 32'd0);

    // Recovery after flush
    user_tready = 1'b1;
    expect_beat({384'h0, mkw(77)}, 4'b0001);
    push_word(mkw(77));
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
